// File: rtl/in_shift_ctrl.sv
// in_shift_ctrl: sequencer for one in_shift_reg lane.
// Loads a feature row, then sweeps f_sel over non-zero taps per window.
module in_shift_ctrl #(
   parameter int N         = 3,
   parameter int SEL_WIDTH = $clog2(N),
   parameter int ROW_MAX   = 64,
   parameter int CNT_WIDTH = $clog2(ROW_MAX+1)
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 start_i,
   input  logic [CNT_WIDTH-1:0] row_len_i,
   input  logic [N-1:0]         mask_i,
   input  logic                 feat_valid_i,
   output logic                 feat_ready_o,
   output logic                 freg_rst_o,
   output logic                 freg_ld_o,
   output logic [SEL_WIDTH-1:0] f_sel_o,
   output logic                 mac_en_o,
   output logic                 win_done_o,
   output logic                 busy_o,
   output logic                 done_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_LOAD,
      S_COMPUTE,
      S_DONE
   } state_t;

   localparam logic [CNT_WIDTH:0] N_W = (CNT_WIDTH+1)'(N);
   localparam logic [CNT_WIDTH:0] ONE_W = (CNT_WIDTH+1)'(1);
   localparam logic [N-1:0] ONE_N = N'(1);

   state_t               state_q, state_d;
   logic [N-1:0]         mask_q, mask_d;
   logic [N-1:0]         rem_q, rem_d;
   logic [CNT_WIDTH-1:0] len_q, len_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   logic [CNT_WIDTH:0]   cnt_inc;
   logic [CNT_WIDTH:0]   len_ext;
   logic [N-1:0]         rem_next;
   logic [SEL_WIDTH-1:0] low_sel;
   logic                 low_found;

   assign cnt_inc  = {1'b0, cnt_q} + ONE_W;
   assign len_ext  = {1'b0, len_q};
   // Drop the lowest set bit; zero when at most one tap remains.
   assign rem_next = rem_q & (rem_q - ONE_N);

   assign busy_o     = (state_q != S_IDLE);
   assign freg_rst_o = ~rst_n_i | (state_q == S_CLEAR);
   assign freg_ld_o  = feat_valid_i & feat_ready_o;

   // Priority encode the lowest remaining non-zero tap.
   always_comb begin
      low_sel   = '0;
      low_found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (rem_q[k] && !low_found) begin
            low_sel   = SEL_WIDTH'(k);
            low_found = 1'b1;
         end
      end
   end

   // State and row context registers.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         mask_q  <= '0;
         rem_q   <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         rem_q   <= rem_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_d      = state_q;
      mask_d       = mask_q;
      rem_d        = rem_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      feat_ready_o = 1'b0;
      f_sel_o      = '0;
      mac_en_o     = 1'b0;
      win_done_o   = 1'b0;
      done_o       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               mask_d  = mask_i;
               len_d   = row_len_i;
               cnt_d   = '0;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            state_d = (len_q == '0) ? S_DONE : S_LOAD;
         end
         S_LOAD: begin
            feat_ready_o = 1'b1;
            if (feat_valid_i) begin
               cnt_d = cnt_inc[CNT_WIDTH-1:0];
               if (cnt_inc == len_ext && cnt_inc < N_W) begin
                  state_d = S_DONE;
               end else if (cnt_inc >= N_W) begin
                  rem_d   = mask_q;
                  state_d = S_COMPUTE;
               end
            end
         end
         S_COMPUTE: begin
            f_sel_o    = low_sel;
            mac_en_o   = |rem_q;
            win_done_o = (rem_next == '0);
            rem_d      = rem_next;
            if (win_done_o) begin
               state_d = (cnt_q == len_q) ? S_DONE : S_LOAD;
            end
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_in_shift_ctrl.sv
// tb_in_shift_ctrl: randomized row stimulus against a
// transaction-level model of the tap sweep and row timing.
module tb_in_shift_ctrl;

   localparam int N  = 3;
   localparam int SW = 2;
   localparam int CW = 7;

   logic          clk = 1'b0;
   logic          rst_n_i;
   logic          start_i;
   logic [CW-1:0] row_len_i;
   logic [N-1:0]  mask_i;
   logic          feat_valid_i;
   logic          feat_ready_o;
   logic          freg_rst_o;
   logic          freg_ld_o;
   logic [SW-1:0] f_sel_o;
   logic          mac_en_o;
   logic          win_done_o;
   logic          busy_o;
   logic          done_o;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   in_shift_ctrl #(
      .N(N),
      .SEL_WIDTH(SW),
      .ROW_MAX(64),
      .CNT_WIDTH(CW)
   ) dut (
      .clk_i(clk),
      .rst_n_i(rst_n_i),
      .start_i(start_i),
      .row_len_i(row_len_i),
      .mask_i(mask_i),
      .feat_valid_i(feat_valid_i),
      .feat_ready_o(feat_ready_o),
      .freg_rst_o(freg_rst_o),
      .freg_ld_o(freg_ld_o),
      .f_sel_o(f_sel_o),
      .mac_en_o(mac_en_o),
      .win_done_o(win_done_o),
      .busy_o(busy_o),
      .done_o(done_o)
   );

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int popc(int m);
      int p = 0;
      for (int k = 0; k < N; k++) p += (m >> k) & 1;
      return p;
   endfunction

   // vmode: 0 valid always, 1 alternate cycles, 2 random.
   task automatic run_row(int len, int mask, int vmode, bit poke);
      int exp_q[$];
      int obs_q[$];
      int w, cpw, c, loads, wins, rdy, done_c, first_c;
      int ld_bad, busy_bad, sel_bad, nd;
      w   = (len >= N) ? len - N + 1 : 0;
      cpw = (popc(mask) > 0) ? popc(mask) : 1;
      for (int i = 0; i < w; i++) begin
         if (mask == 0) exp_q.push_back(1);
         else
            for (int k = 0; k < N; k++)
               if ((mask >> k) & 1)
                  exp_q.push_back(k * 4 + 2 +
                     (((mask >> (k + 1)) == 0) ? 1 : 0));
      end
      loads = 0; wins = 0; rdy = 0; done_c = -1; first_c = -1;
      ld_bad = 0; busy_bad = 0; sel_bad = 0; nd = 0;
      @(negedge clk);
      start_i = 1'b1;
      row_len_i = CW'(len);
      mask_i = N'(mask);
      feat_valid_i = 1'b0;
      @(negedge clk);
      start_i = 1'b0;
      row_len_i = CW'($urandom_range(0, 20));
      mask_i = N'($urandom_range(0, 7));
      c = 1;
      while (nd == 0 && c < 3000) begin
         case (vmode)
            0: feat_valid_i = 1'b1;
            1: feat_valid_i = c[0];
            default: feat_valid_i = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (freg_ld_o) loads++;
         if (freg_ld_o && !feat_valid_i) ld_bad++;
         if (feat_ready_o) rdy++;
         if (mac_en_o || win_done_o) begin
            if (first_c < 0) first_c = c;
            obs_q.push_back(int'(f_sel_o) * 4 +
               int'(mac_en_o) * 2 + int'(win_done_o));
            if (win_done_o) wins++;
         end else if (f_sel_o != '0) sel_bad++;
         if (!busy_o) busy_bad++;
         if (done_o) begin
            nd = 1;
            done_c = c;
         end
         start_i = (poke && mac_en_o) ? 1'b1 : 1'b0;
         if (start_i) begin
            row_len_i = CW'($urandom_range(0, 20));
            mask_i = N'($urandom_range(0, 7));
         end
         @(negedge clk);
         c++;
      end
      start_i = 1'b0;
      feat_valid_i = 1'b0;
      #1;
      chk("done_seen", nd, 1);
      chk("busy_after", busy_o, 0);
      chk("done_after", done_o, 0);
      chk("loads", loads, len);
      chk("windows", wins, w);
      chk("sweep_len", obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         chk("sweep", obs_q[i], exp_q[i]);
      chk("ld_no_valid", ld_bad, 0);
      chk("busy_drop", busy_bad, 0);
      chk("sel_idle", sel_bad, 0);
      if (len == 0) chk("ready_empty", rdy, 0);
      if (vmode == 0) begin
         chk("done_cycle", done_c, len + w * cpw + 2);
         if (w > 0) chk("first_comp", first_c, N + 2);
      end
   endtask

   task automatic mid_reset();
      int c, nd;
      @(negedge clk);
      start_i = 1'b1;
      row_len_i = CW'(10);
      mask_i = N'(3);
      @(negedge clk);
      start_i = 1'b0;
      feat_valid_i = 1'b1;
      c = 0;
      #1;
      while (!feat_ready_o && c < 10) begin
         @(negedge clk);
         #1;
         c++;
      end
      chk("reached_load", feat_ready_o, 1);
      rst_n_i = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_freg", freg_rst_o, 1);
      rst_n_i = 1'b1;
      nd = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (done_o || busy_o) nd++;
      end
      chk("abandoned", nd, 0);
      feat_valid_i = 1'b0;
   endtask

   initial begin
      rst_n_i = 1'b0;
      start_i = 1'b0;
      row_len_i = '0;
      mask_i = '0;
      feat_valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("rst_freg_rst", freg_rst_o, 1);
         chk("rst_ready", feat_ready_o, 0);
         chk("rst_ld", freg_ld_o, 0);
         chk("rst_sel", f_sel_o, 0);
         chk("rst_mac", mac_en_o, 0);
         chk("rst_win", win_done_o, 0);
         chk("rst_busy0", busy_o, 0);
         chk("rst_done0", done_o, 0);
      end
      rst_n_i = 1'b1;
      feat_valid_i = 1'b0;
      @(negedge clk);
      #1;
      chk("idle_busy", busy_o, 0);
      chk("idle_freg_rst", freg_rst_o, 0);

      run_row(5, 5, 0, 0);
      run_row(4, 0, 0, 0);
      run_row(5, 7, 0, 0);
      run_row(4, 2, 1, 0);
      run_row(2, 5, 0, 0);
      run_row(0, 3, 0, 0);
      run_row(6, 5, 0, 1);
      mid_reset();
      run_row(5, 6, 0, 0);
      for (int r = 0; r < 25; r++)
         run_row($urandom_range(0, 12), $urandom_range(0, 7),
                 $urandom_range(0, 2), 1'($urandom_range(0, 1)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/in_shift_ctrl.md
# in_shift_ctrl

Sequencer for one `in_shift_reg` lane of the sparse convolution array. It streams one row of input features into the shift register, then sweeps `f_sel` over only the non-zero weight taps of each N-wide window. Zero taps cost no cycles. It issues one MAC-enable per non-zero tap and a window-done strobe per window. One instance sits beside each input shift register, between the feature fetch path and the PE MAC.

## Interface
Parameters:
- `N`, 3: shift-register depth (kernel width); must match the driven `in_shift_reg`.
- `SEL_WIDTH`, `$clog2(N)`: tap select width.
- `ROW_MAX`, 64: maximum features per row.
- `CNT_WIDTH`, `$clog2(ROW_MAX+1)`: row length / feature counter width.

Ports:
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_n_i`  in  1  reset; synchronous, active-low.
- `start_i`  in  1  start-of-row pulse; sampled only in IDLE.
- `row_len_i`  in  CNT_WIDTH  features in row; latched on accepted start.
- `mask_i`  in  N  non-zero tap mask (bit k = tap k non-zero); latched on accepted start.
- `feat_valid_i`  in  1  upstream feature valid.
- `feat_ready_o`  out  1  controller accepts a feature this cycle.
- `freg_rst_o`  out  1  to `in_shift_reg.freg_rst_i`.
- `freg_ld_o`  out  1  to `in_shift_reg.freg_ld_i`.
- `f_sel_o`  out  SEL_WIDTH  to `in_shift_reg.f_sel_i`.
- `mac_en_o`  out  1  selected feature is valid for MAC this cycle.
- `win_done_o`  out  1  last cycle of current window.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle pulse, row finished.

## Operation
- States: IDLE, CLEAR, LOAD, COMPUTE, DONE. Registers: `state`, `mask_q`, `len_q`, `cnt` (features loaded), `rem` (N-bit remaining-tap mask).
- **IDLE:**
  - On `start_i`: latch `mask_i` and `row_len_i`, clear `cnt`, go to CLEAR.
  - `start_i` in any other state is ignored.
- **CLEAR:** one cycle with `freg_rst_o`=1, then go to LOAD.
- **LOAD:**
  - `feat_ready_o`=1.
  - `freg_ld_o = feat_valid_i & feat_ready_o` (combinational, same cycle).
  - On handshake, `cnt` increments.
  - After a handshake:
    - if `cnt+1 == len_q` and `cnt+1 < N`: go to DONE (short row, no windows).
    - else if `cnt+1 >= N`: go to COMPUTE with `rem <= mask_q`.
    - else stay in LOAD.
  - No handshake: hold.
- **COMPUTE:**
  - `f_sel_o` = index of lowest set bit of `rem`; `mac_en_o`=1; clear that bit in `rem`.
  - `win_done_o`=1 on the cycle where `rem` has exactly one bit set.
  - On that cycle, exit: to DONE if `cnt == len_q`, else to LOAD.
  - **`mask_q == 0`:** exactly one COMPUTE cycle with `mac_en_o`=0, `win_done_o`=1, `f_sel_o`=0.
- **DONE:** `done_o`=1 for one cycle, then go to IDLE.
- Windows per row: `len_q-N+1` if `len_q >= N`, else 0.
- **`row_len_i == 0`:** CLEAR, then DONE, then IDLE; no `feat_ready_o`.
- `f_sel_o` is 0 outside COMPUTE. `mac_en_o`, `win_done_o`, `done_o` and `feat_ready_o` are 0 outside their states.
- **Reset (`rst_n_i`=0):**
  - `state` goes to IDLE; all registers clear.
  - `freg_rst_o = ~rst_n_i | (state==CLEAR)`, so the shift register is also cleared during reset.
  - Reset mid-row abandons the row with no `done_o`. The next start runs normally.

## Timing
- Outputs `f_sel_o`, `mac_en_o`, `win_done_o`, `busy_o`, `done_o` and `feat_ready_o` are decoded from registered state only.
- `freg_ld_o` additionally depends combinationally on `feat_valid_i`.
- Start sampled at cycle t: CLEAR at t+1, first LOAD at t+2.
- With `feat_valid_i` held high, the first COMPUTE is at t+2+N.
- Each window costs popcount(`mask_q`) COMPUTE cycles (minimum 1), plus 1 LOAD cycle before every window after the first.
- Shift-register data for `f_sel_o` is valid combinationally in the same cycle `mac_en_o`=1.
- Backpressure only via `feat_ready_o`; controller never stalls in COMPUTE.

## Test plan
- **Reset values:** hold `rst_n_i`=0 for 3 cycles.
  - All outputs 0 except `freg_rst_o`=1.
  - Release: IDLE, `busy_o`=0.
- **Nominal row:** N=3, `row_len_i`=5, `mask_i`=3'b101, valid always high, start at c0.
  - CLEAR c1; loads c2–c4.
  - COMPUTE c5 (sel 0), c6 (sel 2, `win_done_o`); LOAD c7.
  - COMPUTE c8/c9; LOAD c10; COMPUTE c11/c12.
  - `done_o` at c13; 6 `mac_en_o` pulses, 3 `win_done_o` pulses.
- **Zero and full masks:**
  - `mask_i`=0, `row_len_i`=4: 2 windows, each 1 cycle; `mac_en_o` never high.
  - `mask_i`=3'b111: `f_sel_o` sequence 0,1,2 per window.
- **Backpressure:** `row_len_i`=4, `mask_i`=3'b010, `feat_valid_i` low on alternate cycles.
  - `freg_ld_o` only on valid cycles; exactly 4 loads.
  - 2 windows with `f_sel_o`=1; `done_o` once.
- **Short and empty rows:**
  - `row_len_i`=2: 2 loads, no COMPUTE, `done_o`.
  - `row_len_i`=0: `done_o` at t+2, no `feat_ready_o`.
- **Mid-operation events:**
  - `start_i` pulsed during COMPUTE: ignored, the row completes unchanged.
  - `rst_n_i` low during LOAD: IDLE next cycle, no `done_o`.
  - A fresh start afterwards produces correct windows.
